clock_set_ctrl: RTL and testbench

- Front-panel controller for the clock/calendar counter block.
- Converts four raw push-buttons (mode, next, up, down) into that block's setting interface: set_mode, field_sel, and single-cycle inc/dec pulses.
- Provides debounce, auto-repeat on held up/down, inactivity timeout back to run mode, and a blink phase so the display can flash the field being edited.

---
 rtl/clk_cal_pkg.sv | 28 ++
 rtl/btn_conditioner.sv | 97 +++++++++
 rtl/clock_set_ctrl.sv | 153 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_cal_pkg.sv
// Shared definitions for the clock/calendar block, its front-panel controller
// and the display mux: field indices, setup FSM states and blink phase.
package clk_cal_pkg;

    localparam logic [2:0] FIELD_SEC  = 3'd0;
    localparam logic [2:0] FIELD_MIN  = 3'd1;
    localparam logic [2:0] FIELD_HR   = 3'd2;
    localparam logic [2:0] FIELD_DAY  = 3'd3;
    localparam logic [2:0] FIELD_MON  = 3'd4;
    localparam logic [2:0] FIELD_YR   = 3'd5;
    localparam logic [2:0] FIELD_LAST = FIELD_YR;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } set_state_e;

    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_phase_e;

    // Advance the edited field, wrapping from the last field back to seconds.
    function automatic logic [2:0] next_field(input logic [2:0] f);
        return (f >= FIELD_LAST) ? FIELD_SEC : f + 3'd1;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioning: 2-flop synchronizer, debounce, press pulse
// and optional hold-to-repeat.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_btn      : raw button level, asynchronous to clk
//   i_cancel   : abandons any running repeat until the next press
//   o_level    : debounced level
//   o_press    : one-cycle pulse on the debounced 0->1 transition
//   o_repeat   : one-cycle repeat pulse while held (only when REPEAT_EN)
module btn_conditioner
    import clk_cal_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 20000,
    parameter bit          REPEAT_EN    = 1'b0,
    parameter int unsigned REPEAT_DELAY = 10000000,
    parameter int unsigned REPEAT_RATE  = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    input  logic i_cancel,
    output logic o_level,
    output logic o_press,
    output logic o_repeat
);

    localparam int unsigned DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_RATE  = RW'(REPEAT_RATE);

    logic          r_sync1, r_sync2, r_level, r_press;
    logic [DW-1:0] r_deb_cnt;
    logic          r_rep_act, r_rep_rate;
    logic [RW-1:0] r_rep_cnt;
    logic          w_deb_done, w_rep_fire;
    logic [RW-1:0] w_rep_target;

    // The counter runs only while the synchronized sample differs from the
    // accepted level, so any sample equal to the level restarts it.
    assign w_deb_done = (r_sync2 != r_level) && (r_deb_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_deb_done && r_sync2;
            if (r_sync2 == r_level) begin
                r_deb_cnt <= '0;
            end else if (w_deb_done) begin
                r_level   <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    // r_rep_cnt counts cycles since the press (delay phase) or since the last
    // repeat (rate phase); it restarts at 1 so it never passes its target.
    assign w_rep_target = r_rep_rate ? RPT_RATE : RPT_DELAY;
    assign w_rep_fire   = r_rep_act && r_level && (r_rep_cnt == w_rep_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_act  <= 1'b0;
            r_rep_rate <= 1'b0;
            r_rep_cnt  <= '0;
        end else if (!r_level || i_cancel) begin
            r_rep_act  <= 1'b0;
            r_rep_rate <= 1'b0;
            r_rep_cnt  <= '0;
        end else if (r_press) begin
            r_rep_act  <= 1'b1;
            r_rep_rate <= 1'b0;
            r_rep_cnt  <= RW'(1);
        end else if (w_rep_fire) begin
            r_rep_rate <= 1'b1;
            r_rep_cnt  <= RW'(1);
        end else if (r_rep_act) begin
            r_rep_cnt  <= r_rep_cnt + 1'b1;
        end
    end

    assign o_level  = r_level;
    assign o_press  = r_press;
    // Repeat logic is constant-folded away when REPEAT_EN is 0.
    assign o_repeat = REPEAT_EN & w_rep_fire;

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel controller turning mode/next/up/down buttons into the calendar
// setting interface, with inactivity timeout and edit-field blink.
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick_1s             : one-cycle pulse per second
//   btn_mode/next/up/down : raw buttons, active high, asynchronous
//   set_mode            : 1 while in setup
//   field_sel           : field being edited (FIELD_SEC..FIELD_YR)
//   inc, dec            : one-cycle adjust pulses
//   field_blank         : 1 during the blink off-phase in setup
module clock_set_ctrl
    import clk_cal_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 20000,
    parameter int unsigned REPEAT_DELAY = 10000000,
    parameter int unsigned REPEAT_RATE  = 2500000,
    parameter int unsigned TIMEOUT_S    = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       set_mode,
    output logic [2:0] field_sel,
    output logic       inc,
    output logic       dec,
    output logic       field_blank
);

    localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S);

    logic w_mode_lvl, w_mode_press, w_mode_rep;
    logic w_next_lvl, w_next_press, w_next_rep;
    logic w_up_lvl, w_up_press, w_up_rep;
    logic w_dn_lvl, w_dn_press, w_dn_rep;
    logic w_updn_both, w_up_ev, w_dn_ev;
    logic w_unused;

    // Both adjust buttons held: suppress their events and kill any repeat.
    assign w_updn_both = w_up_lvl & w_dn_lvl;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b0),
                      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_mode (.clk(clk), .rst_n(rst_n), .i_btn(btn_mode), .i_cancel(1'b0),
            .o_level(w_mode_lvl), .o_press(w_mode_press), .o_repeat(w_mode_rep));

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b0),
                      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_next (.clk(clk), .rst_n(rst_n), .i_btn(btn_next), .i_cancel(1'b0),
            .o_level(w_next_lvl), .o_press(w_next_press), .o_repeat(w_next_rep));

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b1),
                      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_up (.clk(clk), .rst_n(rst_n), .i_btn(btn_up), .i_cancel(w_updn_both),
          .o_level(w_up_lvl), .o_press(w_up_press), .o_repeat(w_up_rep));

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_EN(1'b1),
                      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_down (.clk(clk), .rst_n(rst_n), .i_btn(btn_down), .i_cancel(w_updn_both),
            .o_level(w_dn_lvl), .o_press(w_dn_press), .o_repeat(w_dn_rep));

    assign w_unused = ^{w_mode_lvl, w_mode_rep, w_next_lvl, w_next_rep};
    assign w_up_ev  = !w_updn_both && (w_up_press || w_up_rep);
    assign w_dn_ev  = !w_updn_both && (w_dn_press || w_dn_rep);

    set_state_e   r_state, w_state_nx;
    blink_phase_e r_phase, w_phase_nx;
    logic [2:0]    r_field, w_field_nx;
    logic [TW-1:0] r_tcnt, w_tcnt_nx, w_tcnt_inc;
    logic          w_inc_nx, w_dec_nx;
    logic          r_set_mode, r_inc, r_dec, r_blank;

    assign w_tcnt_inc = r_tcnt + 1'b1;

    // Event priority: mode > next > up/down > tick; losers are dropped.
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_field_nx = r_field;
        w_tcnt_nx  = r_tcnt;
        w_inc_nx   = 1'b0;
        w_dec_nx   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mode_press) begin
                    w_state_nx = ST_SET;
                    w_field_nx = FIELD_SEC;
                    w_tcnt_nx  = '0;
                    w_phase_nx = BLINK_ON;
                end
            end
            ST_SET: begin
                if (w_mode_press) begin
                    w_state_nx = ST_RUN;
                    w_tcnt_nx  = '0;
                end else if (w_next_press) begin
                    w_field_nx = next_field(r_field);
                    w_tcnt_nx  = '0;
                    w_phase_nx = BLINK_ON;
                end else if (w_up_ev) begin
                    w_inc_nx   = 1'b1;
                    w_tcnt_nx  = '0;
                    w_phase_nx = BLINK_ON;
                end else if (w_dn_ev) begin
                    w_dec_nx   = 1'b1;
                    w_tcnt_nx  = '0;
                    w_phase_nx = BLINK_ON;
                end else if (tick_1s) begin
                    w_phase_nx = (r_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                    if (w_tcnt_inc == TO_LAST) begin
                        w_state_nx = ST_RUN;
                        w_tcnt_nx  = '0;
                    end else begin
                        w_tcnt_nx  = w_tcnt_inc;
                    end
                end
            end
            default: w_state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_phase    <= BLINK_ON;
            r_field    <= FIELD_SEC;
            r_tcnt     <= '0;
            r_set_mode <= 1'b0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_blank    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_phase    <= w_phase_nx;
            r_field    <= w_field_nx;
            r_tcnt     <= w_tcnt_nx;
            r_set_mode <= (w_state_nx == ST_SET);
            r_inc      <= w_inc_nx;
            r_dec      <= w_dec_nx;
            r_blank    <= (w_state_nx == ST_SET) && (w_phase_nx == BLINK_OFF);
        end
    end

    assign set_mode    = r_set_mode;
    assign field_sel   = r_field;
    assign inc         = r_inc;
    assign dec         = r_dec;
    assign field_blank = r_blank;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 5;
    localparam int TO  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       bm = 1'b0, bn = 1'b0, bu = 1'b0, bd = 1'b0;
    logic       set_mode, inc, dec, field_blank;
    logic [2:0] field_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int edges   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    clock_set_ctrl #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_S(TO)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1s(tick),
        .btn_mode(bm), .btn_next(bn), .btn_up(bu), .btn_down(bd),
        .set_mode(set_mode), .field_sel(field_sel), .inc(inc), .dec(dec),
        .field_blank(field_blank)
    );

    // ---------------- behavioural reference model ----------------
    // Buttons: 0 mode, 1 next, 2 up, 3 down.
    bit m_h1 [4];     // raw level one edge ago
    bit m_h2 [4];     // raw level two edges ago (= synchronized sample)
    bit m_last [4];   // previous synchronized sample
    int m_run [4];    // length of the current run of identical samples
    bit m_lvl [4];
    bit m_press [4];
    bit m_act [4];    // repeat armed since a press
    int m_pc [4];     // cycle index of that press
    int m_c;
    bit e_set, e_inc, e_dec, e_phase_on;
    int e_field, e_tcnt;

    always @(posedge clk or negedge rst_n) begin
        bit raw [4];
        bit rep [4];
        bit both, up_ev, dn_ev, s;
        int k;
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                m_h1[b] = 0; m_h2[b] = 0; m_last[b] = 0; m_run[b] = DEB;
                m_lvl[b] = 0; m_press[b] = 0; m_act[b] = 0; m_pc[b] = 0;
            end
            m_c = 0;
            e_set = 0; e_inc = 0; e_dec = 0; e_phase_on = 1; e_field = 0; e_tcnt = 0;
        end else begin
            raw[0] = bm; raw[1] = bn; raw[2] = bu; raw[3] = bd;
            both = m_lvl[2] && m_lvl[3];
            rep[0] = 0; rep[1] = 0;
            for (int b = 2; b < 4; b++) begin
                k = m_c - m_pc[b];
                rep[b] = m_act[b] && m_lvl[b] && (k >= RD) && (((k - RD) % RR) == 0);
            end
            up_ev = !both && (m_press[2] || rep[2]);
            dn_ev = !both && (m_press[3] || rep[3]);
            e_inc = 0;
            e_dec = 0;
            if (!e_set) begin
                if (m_press[0]) begin
                    e_set = 1; e_field = 0; e_tcnt = 0; e_phase_on = 1;
                end
            end else if (m_press[0]) begin
                e_set = 0; e_tcnt = 0;
            end else if (m_press[1]) begin
                e_field = (e_field + 1) % 6; e_tcnt = 0; e_phase_on = 1;
            end else if (up_ev) begin
                e_inc = 1; e_tcnt = 0; e_phase_on = 1;
            end else if (dn_ev) begin
                e_dec = 1; e_tcnt = 0; e_phase_on = 1;
            end else if (tick) begin
                e_tcnt = e_tcnt + 1;
                e_phase_on = !e_phase_on;
                if (e_tcnt >= TO) e_set = 0;
            end
            for (int b = 2; b < 4; b++) begin
                if (!m_lvl[b] || both) m_act[b] = 0;
                else if (m_press[b]) begin m_act[b] = 1; m_pc[b] = m_c; end
            end
            for (int b = 0; b < 4; b++) begin
                s = m_h2[b];
                m_h2[b] = m_h1[b];
                m_h1[b] = raw[b];
                if (s == m_last[b]) begin
                    if (m_run[b] < DEB) m_run[b] = m_run[b] + 1;
                end else begin
                    m_run[b] = 1;
                end
                m_last[b] = s;
                m_press[b] = 0;
                if (m_run[b] >= DEB && s != m_lvl[b]) begin
                    m_press[b] = s;
                    m_lvl[b] = s;
                end
            end
            m_c++;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        n_tests++;
        if (set_mode !== e_set || inc !== e_inc || dec !== e_dec ||
            field_blank !== (e_set && !e_phase_on) ||
            (e_set && field_sel !== 3'(e_field))) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t set/fld/inc/dec/blank got %b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
                     $time, set_mode, field_sel, inc, dec, field_blank,
                     e_set, e_field, e_inc, e_dec, (e_set && !e_phase_on));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_pulses(input int n, output int ni, output int nd);
        ni = 0; nd = 0;
        repeat (n) begin
            @(negedge clk);
            if (inc === 1'b1) ni++;
            if (dec === 1'b1) nd++;
        end
    endtask

    initial begin
        int t0, lat, found, ni, nd, ni2, nd2, tot;
        int ts[$];
        int exp_t [5];
        exp_t = '{7, 27, 32, 37, 42};

        // reset state
        wait_neg(2);
        chk("reset_outputs", {set_mode, field_sel, inc, dec, field_blank}, 0);
        rst_n = 1'b1;
        wait_neg(2);

        // 1: mode press latency, glitch rejection
        bm = 1'b1; t0 = edges; found = 0; lat = -1;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (set_mode === 1'b1) begin found = 1; lat = edges - t0; end
        end
        chk("t1_mode_latency", lat, 7);
        chk("t1_field0", field_sel, 0);
        wait_neg(3); bm = 1'b0; wait_neg(8);
        bu = 1'b1; wait_neg(3); bu = 1'b0;
        count_pulses(12, ni, nd);
        chk("t1_glitch_no_inc", ni, 0);

        // 2: field cycling, down glitch then clean press
        for (int i = 0; i < 6; i++) begin
            bn = 1'b1; wait_neg(8);
            chk("t2_field_step", field_sel, (i + 1) % 6);
            bn = 1'b0; wait_neg(8);
        end
        tot = 0;
        bd = 1'b1; count_pulses(3, ni, nd); tot += nd;
        bd = 1'b0; count_pulses(6, ni, nd); tot += nd;
        bd = 1'b1; count_pulses(8, ni, nd); tot += nd;
        bd = 1'b0; count_pulses(10, ni, nd); tot += nd;
        chk("t2_one_dec", tot, 1);

        // 3: auto-repeat timing
        bu = 1'b1; t0 = edges;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 38) bu = 1'b0;
            if (inc === 1'b1) ts.push_back(edges - t0);
        end
        chk("t3_inc_count", ts.size(), 5);
        for (int j = 0; j < ts.size() && j < 5; j++) chk("t3_inc_time", ts[j], exp_t[j]);
        wait_neg(10);

        // 4: inactivity timeout and blink
        chk("t4_in_set", set_mode, 1);
        chk("t4_blank_on_phase", field_blank, 0);
        for (int i = 1; i <= 3; i++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            chk("t4_set_after_tick", set_mode, (i < 3) ? 1 : 0);
            chk("t4_blank_after_tick", field_blank, (i == 1) ? 1 : 0);
            wait_neg(4);
        end

        // 5: same-cycle priority and both-held suppression
        bm = 1'b1; wait_neg(8); bm = 1'b0; wait_neg(8);
        chk("t5_enter_set", set_mode, 1);
        bm = 1'b1; bu = 1'b1; count_pulses(8, ni, nd);
        bm = 1'b0; bu = 1'b0; count_pulses(10, ni2, nd2);
        chk("t5_mode_wins_no_inc", ni + ni2, 0);
        chk("t5_back_to_run", set_mode, 0);
        bm = 1'b1; wait_neg(8); bm = 1'b0; wait_neg(8);
        chk("t5_reenter_set", set_mode, 1);
        bu = 1'b1; bd = 1'b1; count_pulses(40, ni, nd);
        bu = 1'b0; bd = 1'b0; count_pulses(10, ni2, nd2);
        chk("t5_both_held_quiet", ni + nd + ni2 + nd2, 0);

        // 6: asynchronous reset mid-repeat, button held through it
        bu = 1'b1; found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (inc === 1'b1) found = 1;
        end
        chk("t6_first_inc", found, 1);
        wait_neg(25);
        chk("t6_pre_reset_set", set_mode, 1);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("t6_async_reset", {set_mode, field_sel, inc, dec, field_blank}, 0);
        wait_neg(3); rst_n = 1'b1;
        count_pulses(30, ni, nd);
        chk("t6_held_no_inc", ni, 0);
        chk("t6_still_run", set_mode, 0);
        bu = 1'b0; wait_neg(10);

        // randomized traffic against the model
        for (int s = 0; s < 150; s++) begin
            int hold;
            hold = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 60 : 12);
            bm = ($urandom_range(0, 99) < 12);
            bn = ($urandom_range(0, 99) < 30);
            bu = ($urandom_range(0, 99) < 35);
            bd = ($urandom_range(0, 99) < 35);
            repeat (hold) begin
                tick = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
            tick = 1'b0;
        end
        bm = 1'b0; bn = 1'b0; bu = 1'b0; bd = 1'b0;
        wait_neg(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
